// File: rtl/wb_stage_mc.sv
// Writeback stage for the 5-stage MIPS pipeline: regfile write, CP0 access,
// multi-cycle TLB operation handshake, flush generation, retired counter and debug trace.
module wb_stage_mc #(
   parameter int DATA_WD = 32,
   parameter int TLBNUM  = 16,
   parameter int CNT_WD  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  ms_to_ws_valid,
   input  logic [54+DATA_WD:0]   ms_to_ws_bus,
   output logic                  ws_allowin,
   output logic [3:0]            rf_we,
   output logic [4:0]            rf_waddr,
   output logic [DATA_WD-1:0]    rf_wdata,
   output logic                  ws_fwd_valid,
   output logic [DATA_WD-1:0]    ws_fwd_data,
   output logic                  cp0_wen_o,
   output logic [7:0]            cp0_addr_o,
   output logic [DATA_WD-1:0]    cp0_wdata,
   input  logic [DATA_WD-1:0]    cp0_rdata,
   output logic                  tlb_req,
   output logic [1:0]            tlb_op_o,
   input  logic                  tlb_ack,
   output logic                  send_flush,
   output logic                  send_tlb_flush,
   output logic [CNT_WD-1:0]     inst_retired,
   output logic [31:0]           debug_wb_pc,
   output logic [3:0]            debug_wb_rf_wen,
   output logic [4:0]            debug_wb_rf_wnum,
   output logic [DATA_WD-1:0]    debug_wb_rf_wdata
);

   localparam int BUS_WD = 55 + DATA_WD;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t              state_reg, state_next;
   logic                ws_valid_reg;
   logic [BUS_WD-1:0]   bus_reg;
   logic [CNT_WD-1:0]   retired_reg;
   logic                ws_ready_go;
   logic                commit;
   logic                wr_commit;

   logic [1:0]          tlb_op;
   logic                exc, eret, cp0_wen, res_from_cp0;
   logic [7:0]          cp0_addr;
   logic [3:0]          gr_we;
   logic [4:0]          dest;
   logic [DATA_WD-1:0]  result;
   logic [31:0]         pc;
   logic [DATA_WD-1:0]  final_result;

   assign {tlb_op, exc, eret, cp0_wen, res_from_cp0, cp0_addr, gr_we, dest, result, pc} = bus_reg;

   // The Index register must be able to hold an entry number.
   generate
      if ($clog2(TLBNUM) > 31) begin : g_tlbnum_unsupported
      end
   endgenerate

   // A TLB request is raised in the first resident cycle, so a same-cycle ack commits at once.
   always_comb begin
      state_next  = state_reg;
      tlb_req     = 1'b0;
      ws_ready_go = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (ws_valid_reg && tlb_op != 2'b00 && !exc) begin
               tlb_req     = 1'b1;
               ws_ready_go = tlb_ack;
               if (!tlb_ack) begin
                  state_next = S_WAIT;
               end
            end else begin
               ws_ready_go = 1'b1;
            end
         end
         S_WAIT: begin
            tlb_req     = 1'b1;
            ws_ready_go = tlb_ack;
            if (tlb_ack) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign ws_allowin = !ws_valid_reg || ws_ready_go;
   assign commit     = ws_valid_reg && ws_ready_go && !flush;
   assign wr_commit  = commit && !exc;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rf_we
         assign rf_we[gi] = gr_we[gi] & wr_commit;
      end
   endgenerate

   assign final_result   = res_from_cp0 ? cp0_rdata : result;
   assign rf_waddr       = dest;
   assign rf_wdata       = final_result;
   assign ws_fwd_valid   = ws_valid_reg && (|gr_we) && !exc;
   assign ws_fwd_data    = final_result;
   assign cp0_wen_o      = wr_commit && cp0_wen;
   assign cp0_addr_o     = (tlb_op == 2'b11) ? 8'd0 : cp0_addr;
   assign cp0_wdata      = result;
   assign tlb_op_o       = tlb_op;
   assign send_flush     = commit && (exc || eret);
   assign send_tlb_flush = wr_commit && (tlb_op == 2'b01 || tlb_op == 2'b10);
   assign inst_retired   = retired_reg;

   assign debug_wb_pc       = pc;
   assign debug_wb_rf_wen   = rf_we;
   assign debug_wb_rf_wnum  = dest;
   assign debug_wb_rf_wdata = final_result;

   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid_reg <= 1'b0;
         state_reg    <= S_IDLE;
         retired_reg  <= '0;
      end else begin
         if (flush) begin
            ws_valid_reg <= 1'b0;
            state_reg    <= S_IDLE;
         end else begin
            if (ws_allowin) begin
               ws_valid_reg <= ms_to_ws_valid;
            end
            state_reg <= state_next;
         end
         if (wr_commit) begin
            retired_reg <= retired_reg + CNT_WD'(1);
         end
      end
   end

   // Payload needs no reset: every consumer is qualified by ws_valid_reg.
   always_ff @(posedge clk) begin
      if (!reset && !flush && ms_to_ws_valid && ws_allowin) begin
         bus_reg <= ms_to_ws_bus;
      end
   end

endmodule

// File: tb/tb_wb_stage_mc.sv
// Randomized self-checking bench for wb_stage_mc against a transaction-level model
// of commit, TLB handshake, flush and retired-count rules.
module tb_wb_stage_mc;
   localparam int DATA_WD = 32;
   localparam int TLBNUM  = 16;
   localparam int CNT_WD  = 4;
   localparam int BUS_WD  = 55 + DATA_WD;

   typedef struct packed {
      logic [1:0]         tlb_op;
      logic               exc;
      logic               eret;
      logic               cp0_wen;
      logic               res_from_cp0;
      logic [7:0]         cp0_addr;
      logic [3:0]         gr_we;
      logic [4:0]         dest;
      logic [DATA_WD-1:0] result;
      logic [31:0]        pc;
   } instr_t;

   logic clk = 1'b0;
   logic reset, flush, ms_to_ws_valid, tlb_ack;
   logic [BUS_WD-1:0]  ms_to_ws_bus;
   logic [DATA_WD-1:0] cp0_rdata;
   logic ws_allowin, ws_fwd_valid, cp0_wen_o, tlb_req, send_flush, send_tlb_flush;
   logic [3:0] rf_we, debug_wb_rf_wen;
   logic [4:0] rf_waddr, debug_wb_rf_wnum;
   logic [DATA_WD-1:0] rf_wdata, ws_fwd_data, cp0_wdata, debug_wb_rf_wdata;
   logic [7:0] cp0_addr_o;
   logic [1:0] tlb_op_o;
   logic [CNT_WD-1:0] inst_retired;
   logic [31:0] debug_wb_pc;

   int errors = 0;
   int checks = 0;
   int model_retired = 0;

   always #5 clk = ~clk;

   wb_stage_mc #(.DATA_WD(DATA_WD), .TLBNUM(TLBNUM), .CNT_WD(CNT_WD)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
      .ws_allowin(ws_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .ws_fwd_valid(ws_fwd_valid), .ws_fwd_data(ws_fwd_data),
      .cp0_wen_o(cp0_wen_o), .cp0_addr_o(cp0_addr_o), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
      .tlb_req(tlb_req), .tlb_op_o(tlb_op_o), .tlb_ack(tlb_ack),
      .send_flush(send_flush), .send_tlb_flush(send_tlb_flush), .inst_retired(inst_retired),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic instr_t rand_instr(bit allow_exc);
      instr_t t;
      t.tlb_op       = 2'b00;
      t.exc          = allow_exc && ($urandom_range(3) == 0);
      t.eret         = ($urandom_range(4) == 0);
      t.cp0_wen      = ($urandom_range(1) == 1);
      t.res_from_cp0 = ($urandom_range(1) == 1);
      t.cp0_addr     = 8'($urandom);
      t.gr_we        = 4'($urandom);
      t.dest         = 5'($urandom);
      t.result       = DATA_WD'($urandom);
      t.pc           = $urandom;
      return t;
   endfunction

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; ms_to_ws_valid = 1'b0; tlb_ack = 1'b0;
      ms_to_ws_bus = '0; cp0_rdata = '0;
      tick(); tick(); #1;
      checks++;
      if ({rf_we, cp0_wen_o, tlb_req, send_flush, send_tlb_flush} !== 8'd0) begin
         errors++; $display("FAIL reset_strobes: got %b required 0", {rf_we, cp0_wen_o, tlb_req, send_flush, send_tlb_flush});
      end
      checks++;
      if ({ws_allowin, ws_fwd_valid} !== 2'b10) begin
         errors++; $display("FAIL reset_valid: allowin/fwd_valid got %b required 10", {ws_allowin, ws_fwd_valid});
      end
      checks++;
      if (inst_retired !== CNT_WD'(0)) begin
         errors++; $display("FAIL reset_retired: got %0d required 0", inst_retired);
      end
      model_retired = 0;
      reset = 1'b0;
      tick();
      $display("reset: done");
   endtask

   task automatic test_alu(int n);
      for (int i = 0; i < n; i++) begin
         instr_t in;
         logic [3:0] exp_we;
         logic [DATA_WD-1:0] exp_wd;
         in = rand_instr(i != 0);
         if (i == 0) begin
            in.gr_we = 4'hF; in.dest = 5'd5; in.result = 32'h1234;
            in.res_from_cp0 = 1'b0; in.eret = 1'b0; in.cp0_wen = 1'b0;
         end
         ms_to_ws_valid = 1'b1; ms_to_ws_bus = in; #1;
         checks++;
         if (ws_allowin !== 1'b1) begin
            errors++; $display("FAIL alu_allowin: got %b required 1", ws_allowin);
         end
         tick();
         ms_to_ws_valid = 1'b0; cp0_rdata = DATA_WD'($urandom); #1;
         exp_we = in.exc ? 4'h0 : in.gr_we;
         exp_wd = in.res_from_cp0 ? cp0_rdata : in.result;
         checks++;
         if ({rf_we, rf_waddr, rf_wdata} !== {exp_we, in.dest, exp_wd}) begin
            errors++; $display("FAIL alu_rf: we/addr/data got %h/%0d/%h required %h/%0d/%h", rf_we, rf_waddr, rf_wdata, exp_we, in.dest, exp_wd);
         end
         checks++;
         if ({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, ws_fwd_data, debug_wb_pc} !== {exp_we, in.dest, exp_wd, exp_wd, in.pc}) begin
            errors++; $display("FAIL alu_trace: pc/wen/wdata got %h/%h/%h required %h/%h/%h", debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wdata, in.pc, exp_we, exp_wd);
         end
         checks++;
         if ({cp0_wen_o, send_flush, send_tlb_flush, tlb_req} !== {in.cp0_wen && !in.exc, in.exc || in.eret, 1'b0, 1'b0}) begin
            errors++; $display("FAIL alu_ctrl: cp0_wen/flush/tlbflush/req got %b required %b", {cp0_wen_o, send_flush, send_tlb_flush, tlb_req}, {in.cp0_wen && !in.exc, in.exc || in.eret, 2'b00});
         end
         checks++;
         if ({ws_fwd_valid, cp0_addr_o, cp0_wdata} !== {(|in.gr_we) && !in.exc, in.cp0_addr, in.result}) begin
            errors++; $display("FAIL alu_fwd_cp0: fwd/addr/wdata got %b/%h/%h required %b/%h/%h", ws_fwd_valid, cp0_addr_o, cp0_wdata, (|in.gr_we) && !in.exc, in.cp0_addr, in.result);
         end
         if (!in.exc) model_retired++;
         tick(); #1;
         checks++;
         if ({rf_we, send_flush, cp0_wen_o} !== 6'd0 || inst_retired !== CNT_WD'(model_retired)) begin
            errors++; $display("FAIL alu_after: strobes %b retired %0d required 0 and %0d", {rf_we, send_flush, cp0_wen_o}, inst_retired, CNT_WD'(model_retired));
         end
         $display("alu: pc=%h exc=%b dest=%0d we=%h retired=%0d", in.pc, in.exc, in.dest, exp_we, inst_retired);
      end
   endtask

   task automatic test_tlb(int n);
      for (int i = 0; i < n; i++) begin
         instr_t in, nxt;
         int d;
         logic [5:0] exp_s;
         in = rand_instr(1'b1);
         in.tlb_op = 2'($urandom_range(3, 1));
         d = $urandom_range(3);
         nxt = rand_instr(1'b0);
         ms_to_ws_valid = 1'b1; ms_to_ws_bus = in;
         tick();
         ms_to_ws_bus = nxt;
         if (in.exc) begin
            #1;
            checks++;
            if ({tlb_req, rf_we, cp0_wen_o, send_flush, send_tlb_flush} !== 8'b0000_0010) begin
               errors++; $display("FAIL tlb_exc: req/we/cp0/flush/tlbflush got %b required 00000010", {tlb_req, rf_we, cp0_wen_o, send_flush, send_tlb_flush});
            end
            tick();
         end else begin
            for (int k = 0; k <= d; k++) begin
               tlb_ack = (k == d); #1;
               checks++;
               if ({tlb_req, tlb_op_o, cp0_addr_o, rf_waddr} !== {1'b1, in.tlb_op, (in.tlb_op == 2'b11) ? 8'd0 : in.cp0_addr, in.dest}) begin
                  errors++; $display("FAIL tlb_req: req/op/cp0addr/dest got %b/%b/%h/%0d required 1/%b/%h/%0d", tlb_req, tlb_op_o, cp0_addr_o, rf_waddr, in.tlb_op, (in.tlb_op == 2'b11) ? 8'd0 : in.cp0_addr, in.dest);
               end
               checks++;
               if (ws_allowin !== (k == d)) begin
                  errors++; $display("FAIL tlb_allowin: cycle %0d got %b required %b", k, ws_allowin, k == d);
               end
               exp_s = (k == d) ? {in.gr_we, in.cp0_wen, in.tlb_op != 2'b11} : 6'd0;
               checks++;
               if ({rf_we, cp0_wen_o, send_tlb_flush} !== exp_s) begin
                  errors++; $display("FAIL tlb_commit: cycle %0d got %b required %b", k, {rf_we, cp0_wen_o, send_tlb_flush}, exp_s);
               end
               tick();
            end
            tlb_ack = 1'b0;
            model_retired++;
         end
         ms_to_ws_valid = 1'b0; #1;
         checks++;
         if ({tlb_req, rf_we, rf_waddr} !== {1'b0, nxt.gr_we, nxt.dest} || inst_retired !== CNT_WD'(model_retired)) begin
            errors++; $display("FAIL tlb_next: req/we/dest/retired got %b/%h/%0d/%0d required 0/%h/%0d/%0d", tlb_req, rf_we, rf_waddr, inst_retired, nxt.gr_we, nxt.dest, CNT_WD'(model_retired));
         end
         model_retired++;
         tick();
         $display("tlb: op=%b exc=%b ack_delay=%0d retired=%0d", in.tlb_op, in.exc, d, inst_retired);
      end
   endtask

   task automatic test_flush();
      instr_t in, other;
      in = rand_instr(1'b0);
      in.tlb_op = 2'b01;
      ms_to_ws_valid = 1'b1; ms_to_ws_bus = in;
      tick();
      ms_to_ws_valid = 1'b0; tlb_ack = 1'b0; #1;
      checks++;
      if (tlb_req !== 1'b1) begin
         errors++; $display("FAIL flush_wait1: tlb_req got %b required 1", tlb_req);
      end
      tick();
      flush = 1'b1; #1;
      checks++;
      if ({tlb_req, rf_we, cp0_wen_o, send_flush, send_tlb_flush} !== 8'b1000_0000) begin
         errors++; $display("FAIL flush_wait2: req/we/cp0/flush/tlbflush got %b required 10000000", {tlb_req, rf_we, cp0_wen_o, send_flush, send_tlb_flush});
      end
      tick();
      flush = 1'b0; tlb_ack = 1'b1; #1;
      checks++;
      if ({tlb_req, rf_we, send_tlb_flush, ws_allowin, ws_fwd_valid} !== 8'b0000_0010) begin
         errors++; $display("FAIL flush_late_ack: req/we/tlbflush/allowin/fwd got %b required 00000010", {tlb_req, rf_we, send_tlb_flush, ws_allowin, ws_fwd_valid});
      end
      tick();
      tlb_ack = 1'b0; #1;
      checks++;
      if (inst_retired !== CNT_WD'(model_retired) || tlb_req !== 1'b0) begin
         errors++; $display("FAIL flush_retired: retired/req got %0d/%b required %0d/0", inst_retired, tlb_req, CNT_WD'(model_retired));
      end
      in = rand_instr(1'b0);
      in.gr_we = 4'hF;
      other = rand_instr(1'b0);
      ms_to_ws_valid = 1'b1; ms_to_ws_bus = in;
      tick();
      ms_to_ws_bus = other; flush = 1'b1; #1;
      checks++;
      if ({rf_we, cp0_wen_o, send_flush} !== 6'd0) begin
         errors++; $display("FAIL flush_alu: we/cp0/flush got %b required 0", {rf_we, cp0_wen_o, send_flush});
      end
      tick();
      flush = 1'b0; ms_to_ws_valid = 1'b0; #1;
      checks++;
      if ({ws_fwd_valid, rf_we} !== 5'd0 || inst_retired !== CNT_WD'(model_retired)) begin
         errors++; $display("FAIL flush_capture: fwd/we got %b retired %0d required 0 and %0d", {ws_fwd_valid, rf_we}, inst_retired, CNT_WD'(model_retired));
      end
      tick();
      $display("flush: retired=%0d", inst_retired);
   endtask

   task automatic test_back_to_back_wrap();
      instr_t in, prev;
      reset = 1'b1; tick(); reset = 1'b0; model_retired = 0;
      prev = '0;
      for (int i = 0; i < 17; i++) begin
         in = rand_instr(1'b0);
         ms_to_ws_valid = 1'b1; ms_to_ws_bus = in; #1;
         if (i > 0) begin
            checks++;
            if ({ws_allowin, rf_we, rf_waddr} !== {1'b1, prev.gr_we, prev.dest} || inst_retired !== CNT_WD'(model_retired)) begin
               errors++; $display("FAIL b2b_commit %0d: allowin/we/dest/retired got %b/%h/%0d/%0d required 1/%h/%0d/%0d", i, ws_allowin, rf_we, rf_waddr, inst_retired, prev.gr_we, prev.dest, CNT_WD'(model_retired));
            end
            model_retired++;
         end
         tick();
         prev = in;
      end
      ms_to_ws_valid = 1'b0; #1;
      checks++;
      if (rf_we !== prev.gr_we) begin
         errors++; $display("FAIL b2b_last: we got %h required %h", rf_we, prev.gr_we);
      end
      model_retired++;
      tick(); #1;
      checks++;
      if (inst_retired !== CNT_WD'(model_retired)) begin
         errors++; $display("FAIL wrap_count: got %0d required %0d", inst_retired, CNT_WD'(model_retired));
      end
      $display("wrap: commits=%0d retired=%0d", model_retired, inst_retired);
      in = rand_instr(1'b0);
      ms_to_ws_valid = 1'b1; ms_to_ws_bus = in;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; ms_to_ws_valid = 1'b0; #1;
      model_retired = 0;
      checks++;
      if ({ws_fwd_valid, rf_we, ws_allowin} !== 6'b000001 || inst_retired !== CNT_WD'(model_retired)) begin
         errors++; $display("FAIL mid_reset: fwd/we/allowin got %b retired %0d required 000001 and 0", {ws_fwd_valid, rf_we, ws_allowin}, inst_retired);
      end
      tick();
      $display("mid_reset: retired=%0d", inst_retired);
   endtask

   initial begin
      test_reset();
      test_alu(20);
      test_tlb(24);
      test_flush();
      test_back_to_back_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
